i2c_target_adv7511_model: RTL and testbench

- Synthesizable I2C target (responder) that emulates the ADV7511 register interface at the other end of the team's I2C initiator bus.
- Samples SCL/SDA with the system clock, decodes START/STOP/repeated START, matches a 7-bit device address and hosts a byte-wide register file.
- Used on-chip as a loopback target and in benches to check the initiator's ROM-driven configuration sequence without the real transmitter.

---
 rtl/i2c_target_adv7511_model.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_target_adv7511_model.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_adv7511_model.sv
// I2C target emulating the ADV7511 register map.
// Oversamples SCL/SDA, decodes bus events and hosts a byte register file.
module i2c_target_adv7511_model #(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         NREGS       = 256,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o,
  input  logic [7:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

  localparam int PW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_ACK
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_ev;
  logic stop_ev;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [7:0]      sr_q;
  logic            rw_q;
  logic [PW-1:0]   ptr_q;
  logic [7:0]      mem_q [NREGS];
  logic            sda_oe_q;
  logic            busy_q;
  logic            wr_valid_q;
  logic [7:0]      wr_addr_q;
  logic [7:0]      wr_data_q;
  logic [7:0]      dbg_data_q;

  logic [7:0] sr_in;
  logic [7:0] rd_byte;

  // Synchronize both bus lines, then keep one delayed copy for edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
      sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  // Bus event decode; START/STOP need SCL high on both samples.
  always_comb begin
    scl_s    = scl_sync_q[SYNC_STAGES-1];
    sda_s    = sda_sync_q[SYNC_STAGES-1];
    scl_rise = scl_s & ~scl_dly_q;
    scl_fall = ~scl_s & scl_dly_q;
    start_ev = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    stop_ev  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
    sr_in    = {sr_q[6:0], sda_s};
    rd_byte  = mem_q[ptr_q];
  end

  // Protocol FSM with registered outputs and the register file.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 8'd0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      for (int i = 0; i < NREGS; i++) mem_q[i] <= 8'd0;
    end else begin
      wr_valid_q <= 1'b0;
      if (stop_ev) begin
        state_q  <= S_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_ev) begin
        state_q  <= S_ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
          end
          S_ADDR: begin
            if (scl_rise && cnt_q != 4'd8) begin
              sr_q  <= sr_in;
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (sr_q[7:1] == DEV_ADDR) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                rw_q     <= sr_q[0];
                state_q  <= S_ADDR_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                sr_q     <= rd_byte;
                sda_oe_q <= ~rd_byte[7];
                ptr_q    <= ptr_q + PW'(1);
                cnt_q    <= 4'd1;
                state_q  <= S_RD;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= 4'd0;
                state_q  <= S_PTR;
              end
            end
          end
          S_PTR: begin
            if (scl_rise && cnt_q != 4'd8) begin
              sr_q  <= sr_in;
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              ptr_q    <= sr_q[PW-1:0];
              sda_oe_q <= 1'b1;
              state_q  <= S_PTR_ACK;
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= 4'd0;
              state_q  <= S_WR;
            end
          end
          S_WR: begin
            if (scl_rise && cnt_q != 4'd8) begin
              sr_q  <= sr_in;
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                wr_valid_q   <= 1'b1;
                wr_addr_q    <= 8'(ptr_q);
                wr_data_q    <= sr_in;
                mem_q[ptr_q] <= sr_in;
                ptr_q        <= ptr_q + PW'(1);
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              sda_oe_q <= 1'b1;
              state_q  <= S_WR_ACK;
            end
          end
          S_RD: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RD_ACK;
              end else begin
                sda_oe_q <= ~sr_q[6];
                sr_q     <= {sr_q[6:0], 1'b0};
                cnt_q    <= cnt_q + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise && sda_s) begin
              state_q <= S_IDLE;
            end else if (scl_fall) begin
              sr_q     <= rd_byte;
              sda_oe_q <= ~rd_byte[7];
              ptr_q    <= ptr_q + PW'(1);
              cnt_q    <= 4'd1;
              state_q  <= S_RD;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Debug port reads the pre-write contents of the addressed register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) dbg_data_q <= 8'd0;
    else          dbg_data_q <= mem_q[dbg_addr_i[PW-1:0]];
  end

  assign sda_oe_o   = sda_oe_q;
  assign busy_o     = busy_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign dbg_data_o = dbg_data_q;

endmodule

// File: tb/tb_i2c_target_adv7511_model.sv
// Directed bench for the ADV7511 I2C target model.
// Write pulses are checked against a queue of expected (addr,data) pairs.
module tb_i2c_target_adv7511_model;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] dbg_addr = 8'd0;
  logic [7:0] dbg_data;
  wire        sda_bus = sda_drv & ~sda_oe;

  int total = 0;
  int bad = 0;
  logic [15:0] sb[$];
  bit oe_seen = 1'b0;

  always #5 clk = ~clk;

  i2c_target_adv7511_model dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write pulse must match the oldest entry.
  always @(negedge clk) begin
    logic [15:0] e;
    if (sda_oe) oe_seen = 1'b1;
    if (rst_n && wr_valid) begin
      e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
      chk("wr_pulse", {16'h0, wr_addr, wr_data}, {16'h0, e});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic qw;
    #(Q);
  endtask

  task automatic i2c_start;
    sda_drv = 1'b1; scl = 1'b1; qw;
    sda_drv = 1'b0; qw;
    scl = 1'b0; qw;
  endtask

  task automatic i2c_rstart;
    sda_drv = 1'b1; qw;
    scl = 1'b1; qw;
    sda_drv = 1'b0; qw;
    scl = 1'b0; qw;
  endtask

  task automatic i2c_stop;
    sda_drv = 1'b0; qw;
    scl = 1'b1; qw;
    sda_drv = 1'b1; qw;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; qw;
    scl = 1'b1; qw;
    qw;
    scl = 1'b0; qw;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; qw;
    scl = 1'b1; qw;
    ack = sda_oe;
    qw;
    scl = 1'b0; qw;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_drv = 1'b1; qw;
      scl = 1'b1; qw;
      b = {b[6:0], sda_bus};
      qw;
      scl = 1'b0; qw;
    end
    send_bit(nack);
    sda_drv = 1'b1;
  endtask

  task automatic dbg_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    dbg_addr = a;
    @(negedge clk);
    d = dbg_data;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;

    // reset state
    #23;
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_dbg", dbg_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #(4 * Q);

    // single write 0x41 <= 0x10
    i2c_start;
    wbyte(8'h72, ack);
    chk("t1_addr_ack", ack, 1);
    chk("t1_busy_on", busy, 1);
    wbyte(8'h41, ack);
    chk("t1_ptr_ack", ack, 1);
    sb.push_back(16'h4110);
    wbyte(8'h10, ack);
    chk("t1_data_ack", ack, 1);
    i2c_stop;
    chk("t1_busy_off", busy, 0);
    dbg_rd(8'h41, d);
    chk("t1_dbg_41", d, 8'h10);

    // burst with pointer wrap
    i2c_start;
    wbyte(8'h72, ack);
    wbyte(8'hFE, ack);
    sb.push_back(16'hFEAA);
    wbyte(8'hAA, ack);
    sb.push_back(16'hFFBB);
    wbyte(8'hBB, ack);
    sb.push_back(16'h00CC);
    wbyte(8'hCC, ack);
    chk("t2_last_ack", ack, 1);
    i2c_stop;
    dbg_rd(8'hFE, d);
    chk("t2_dbg_fe", d, 8'hAA);
    dbg_rd(8'hFF, d);
    chk("t2_dbg_ff", d, 8'hBB);
    dbg_rd(8'h00, d);
    chk("t2_dbg_00", d, 8'hCC);

    // preload 0x42 then pointer write, Sr, read two bytes
    i2c_start;
    wbyte(8'h72, ack);
    wbyte(8'h42, ack);
    sb.push_back(16'h425A);
    wbyte(8'h5A, ack);
    i2c_stop;
    i2c_start;
    wbyte(8'h72, ack);
    wbyte(8'h41, ack);
    i2c_rstart;
    wbyte(8'h73, ack);
    chk("t3_rd_addr_ack", ack, 1);
    rbyte(1'b0, d);
    chk("t3_rd0", d, 8'h10);
    rbyte(1'b1, d);
    chk("t3_rd1", d, 8'h5A);
    chk("t3_nack_release", sda_oe, 0);
    chk("t3_busy_before_stop", busy, 1);
    i2c_stop;
    chk("t3_busy_off", busy, 0);

    // foreign address is ignored
    oe_seen = 1'b0;
    i2c_start;
    wbyte(8'h74, ack);
    chk("t4_no_ack", ack, 0);
    chk("t4_busy", busy, 0);
    wbyte(8'h55, ack);
    chk("t4_no_data_ack", ack, 0);
    i2c_stop;
    chk("t4_oe_never", oe_seen, 0);

    // reset while driving a 0 read bit
    i2c_start;
    wbyte(8'h72, ack);
    wbyte(8'h41, ack);
    i2c_rstart;
    wbyte(8'h73, ack);
    chk("t5_drive_bit0", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_release", sda_oe, 0);
    sda_drv = 1'b1;
    #(Q);
    scl = 1'b1;
    #(Q);
    @(negedge clk);
    rst_n = 1'b1;
    #(2 * Q);
    dbg_rd(8'h41, d);
    chk("t5_dbg_41", d, 8'h00);
    dbg_rd(8'hFE, d);
    chk("t5_dbg_fe", d, 8'h00);
    i2c_start;
    wbyte(8'h72, ack);
    chk("t5_post_ack", ack, 1);
    wbyte(8'h10, ack);
    sb.push_back(16'h1033);
    wbyte(8'h33, ack);
    chk("t5_post_data_ack", ack, 1);
    i2c_stop;
    dbg_rd(8'h10, d);
    chk("t5_dbg_10", d, 8'h33);

    // STOP in the middle of a data byte
    i2c_start;
    wbyte(8'h72, ack);
    wbyte(8'h20, ack);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop;
    chk("t6_busy", busy, 0);
    dbg_rd(8'h20, d);
    chk("t6_dbg_20", d, 8'h00);
    scl = 1'b0;
    qw;
    wbyte(8'h72, ack);
    chk("t6_idle_no_ack", ack, 0);
    i2c_stop;

    #(4 * Q);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
